uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares one UART transmitter among NUM_REQ byte-stream requesters (CPU, debug, status) with round-robin fairness.
// - Owns a packet lock: the grant holds from the first byte to the byte flagged last.
// - Sequences the transmitter via a 1-cycle tx_start, then tracks its tx_idle level; sits between requester logic and the UART TX core.
// PARAMETERS
// - NUM_REQ      4    number of requesters, 2..8
// - DATA_WIDTH   8    byte width; matches the UART core
// - HOLD_TIMEOUT 1024 clk cycles a locked owner may stall between bytes before the lock is forcibly released
// PORTS
// - clk          in   1              single clock, all logic on posedge
// - rst          in   1              synchronous, active-high reset
// - req_valid    in   NUM_REQ        per-requester byte available
// - req_data     in   NUM_REQ*DW     packed bytes; requester i at [i*DW +: DW]
// - req_last     in   NUM_REQ        qualifies req_valid: byte ends the packet
// - req_ready    out  NUM_REQ        one-hot accept strobe; byte consumed when valid&ready
// - tx_start     out  1              1-cycle pulse; transmitter latches tx_data
// - tx_data      out  DW             byte to the transmitter, stable while tx_start is high
// - tx_idle      in   1              transmitter idle level (high = no frame in progress)
// - grant_valid  out  1              a requester currently owns the transmitter
// - grant_id     out  clog2(NUM_REQ) current or last owner index
// - timeout_err  out  1              1-cycle pulse when HOLD_TIMEOUT expires
// BEHAVIOUR
// - Reset (sync, high): state=IDLE; all outputs 0; rr_ptr=NUM_REQ-1, so requester 0 wins first; hold_cnt=0. Reset mid-frame drops the lock; the next arbitration waits for tx_idle=1.
// - States: IDLE, SEND, WAIT_BUSY, WAIT_IDLE, HOLD.
// - IDLE: when tx_idle=1 and any req_valid, pick the first set bit searching rr_ptr+1, +2, ... modulo NUM_REQ. The same cycle:
//   - assert req_ready[win] and register tx_data=req_data[win];
//   - latch owner=win and is_last=req_last[win]; set grant_valid=1 and grant_id=win; go to SEND.
// - SEND: tx_start=1 for exactly this cycle, then WAIT_BUSY. Latency req accept -> tx_start is 1 cycle.
// - WAIT_BUSY: wait for tx_idle=0, then WAIT_IDLE. No timeout here.
// - WAIT_IDLE: wait for tx_idle=1. Then:
//   - if is_last: rr_ptr=owner, grant_valid=0, go to IDLE;
//   - otherwise: hold_cnt=0, go to HOLD.
// - HOLD: only the owner is served; other requesters' req_valid are ignored.
//   - If req_valid[owner]: accept as in IDLE (ready pulse, load tx_data, update is_last), then SEND.
//   - Else increment hold_cnt. At hold_cnt==HOLD_TIMEOUT-1: pulse timeout_err, set rr_ptr=owner and grant_valid=0, go to IDLE.
// - req_ready is never high for more than one requester, and never outside IDLE or HOLD accept cycles.
// - A single-byte packet (valid&last in IDLE) goes IDLE -> SEND -> WAIT_BUSY -> WAIT_IDLE -> IDLE.
// - If req_valid and tx_idle=0 in IDLE (after reset), hold off; no accept.
// - Owner switching: the only switch point is IDLE. rr_ptr updates only on packet end or timeout.
// - grant_id holds its value when grant_valid=0.
// - hold_cnt is wide enough for HOLD_TIMEOUT with no wrap; it saturates.
// STRUCTURE
// - Shared package uart_pkg: state encoding localparams, and a clog2 function or constant shared with the UART rx/tx cores.
// - One sub-module: rr_pick #(NUM_REQ), combinational.
//   - Inputs: req vector and rr_ptr. Outputs: win index and any_req.
//   - Implemented with a doubled-vector priority search.
// - The FSM, hold counter and output registers stay in this module.
// TESTING
// - Reset, then req_valid=4'b0001, last=1, data=8'hA5 -> ready[0] 1 cycle; tx_start next cycle with tx_data=A5; grant_id=0; IDLE once tx_idle rises.
// - Requesters 0 and 2 both valid with single-byte packets, repeatedly -> grants alternate 0, 2, 0, 2; no requester gets two grants in a row.
// - Requester 1 sends a 3-byte packet (last on byte 3) while 3 is valid -> bytes 1a, 1b, 1c transmitted contiguously; requester 3 is served only after 1c's frame.
// - Owner 2 stalls after byte 1 with HOLD_TIMEOUT=16 -> timeout_err pulses 16 cycles into HOLD; grant_valid falls; a pending requester 3 is granted next.
// - rst asserted in WAIT_IDLE with tx_idle=0 and req_valid pending -> outputs 0 next cycle; no req_ready or tx_start until tx_idle=1.
// - tx_idle never drops after tx_start -> FSM stays in WAIT_BUSY; no further req_ready and no timeout_err (checked by assertion).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and width helper.
// Also imported by the UART rx/tx cores.
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_SEND      = ST_SEND,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_IDLE = ST_WAIT_IDLE,
    S_HOLD      = ST_HOLD
  } arb_state_t;

  // Never returns less than 1 so single-entry fields stay legal.
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle around the UART TX arbiter.
// master: requesters + UART core side, slave: the arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IW = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_idle;
  logic                          grant_valid;
  logic [IW-1:0]                 grant_id;
  logic                          timeout_err;

  modport master (
    output req_valid, req_data, req_last,
    output tx_idle,
    input  req_ready, tx_start, tx_data,
    input  grant_valid, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last,
    input  tx_idle,
    output req_ready, tx_start, tx_data,
    output grant_valid, grant_id, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request after rr_ptr, wrapping.
// Doubling the vector turns the wrap into a plain priority search.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      win,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] dbl;

  always_comb begin
    dbl     = {req, req} >> (int'(rr_ptr) + 1);
    win     = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        any_req = 1'b1;
        win     = IW'((int'(rr_ptr) + 1 + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter.
// Accepts a byte, pulses tx_start, then follows tx_idle busy/idle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int HOLD_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = clog2(NUM_REQ);
  localparam int HW = clog2(HOLD_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);

  arb_state_t            state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         win;
  logic [IW-1:0]         acc_id;
  logic [IW-1:0]         grant_id;
  logic [HW-1:0]         hold_cnt;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  any_req;
  logic                  accept;
  logic                  is_last;
  logic                  tx_start;
  logic                  grant_valid;
  logic                  timeout_err;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .any_req (any_req)
  );

  // Ready is the accept decision itself, so it is combinational.
  always_comb begin
    accept    = 1'b0;
    acc_id    = win;
    req_ready = '0;
    if (!rst) begin
      unique case (state)
        S_IDLE: accept = bus.tx_idle & any_req;
        S_HOLD: begin
          acc_id = owner;
          accept = bus.req_valid[owner];
        end
        default: ;
      endcase
    end
    if (accept) req_ready[acc_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= IW'(NUM_REQ - 1);
      owner       <= '0;
      is_last     <= 1'b0;
      hold_cnt    <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      if (accept) begin
        tx_data     <= bus.req_data[int'(acc_id)*DATA_WIDTH +: DATA_WIDTH];
        owner       <= acc_id;
        is_last     <= bus.req_last[acc_id];
        grant_valid <= 1'b1;
        grant_id    <= acc_id;
        tx_start    <= 1'b1;
        state       <= S_SEND;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_SEND: state <= S_WAIT_BUSY;
          S_WAIT_BUSY: if (!bus.tx_idle) state <= S_WAIT_IDLE;
          S_WAIT_IDLE: begin
            if (bus.tx_idle) begin
              if (is_last) begin
                rr_ptr      <= owner;
                grant_valid <= 1'b0;
                state       <= S_IDLE;
              end else begin
                hold_cnt <= '0;
                state    <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              timeout_err <= 1'b1;
              rr_ptr      <= owner;
              grant_valid <= 1'b0;
              state       <= S_IDLE;
            end else if (hold_cnt != '1) begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.tx_start    = tx_start;
  assign bus.tx_data     = tx_data;
  assign bus.grant_valid = grant_valid;
  assign bus.grant_id    = grant_id;
  assign bus.timeout_err = timeout_err;

endmodule
